// File: rtl/bsg_noc_credit_pkg.sv
// Shared definitions for credit-flow link endpoints.
//   credit_width()      : bits needed to hold a credit count in 0..els
//   credit_cfg_e        : outcome of the els/step legality check
//   credit_cfg_check()  : classifies an (els, step) pair at elaboration
package bsg_noc_credit_pkg;

  typedef enum logic [1:0] {
    CFG_OK,
    CFG_ELS_ZERO,
    CFG_STEP_ZERO,
    CFG_STEP_UNEVEN
  } credit_cfg_e;

  function automatic int unsigned credit_width(input int unsigned els);
    return $clog2(els + 1);
  endfunction

  // Credits only come back in whole steps, so a pool that is not a multiple
  // of the step could never be refilled exactly to els.
  function automatic credit_cfg_e credit_cfg_check(input int unsigned els,
                                                   input int unsigned step);
    if (els == 0)
      return CFG_ELS_ZERO;
    if (step == 0)
      return CFG_STEP_ZERO;
    if ((els % step) != 0)
      return CFG_STEP_UNEVEN;
    return CFG_OK;
  endfunction

endpackage

// File: rtl/bsg_fifo_credit_counter.sv
// Up/down saturating credit counter.
//   clk_i, reset_i : clock and synchronous active-high reset (count -> els_p)
//   dec_i          : consume one credit
//   inc_i          : return step_p credits
//   count_o        : current credit count, 0..els_p
//   overflow_o     : sticky, set when a return would exceed els_p
module bsg_fifo_credit_counter
  import bsg_noc_credit_pkg::*;
#(
  parameter int unsigned els_p  = 4,
  parameter int unsigned step_p = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           dec_i,
  input  logic                           inc_i,
  output logic [credit_width(els_p)-1:0] count_o,
  output logic                           overflow_o
);

  localparam int unsigned CW = credit_width(els_p);

  // One extra bit so count + step can exceed els_p without wrapping.
  typedef logic [CW:0] wide_t;

  localparam wide_t ELS_W  = wide_t'(els_p);
  localparam wide_t STEP_W = wide_t'(step_p);

  logic [CW-1:0] count_r;
  logic          overflow_r;
  logic          dec_ok;
  wide_t         sum;
  logic          sat;

  always_comb begin
    dec_ok = dec_i && (count_r != '0);
    sum    = {1'b0, count_r} + (inc_i ? STEP_W : '0) - wide_t'(dec_ok);
    sat    = (sum > ELS_W);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      count_r    <= CW'(els_p);
      overflow_r <= 1'b0;
    end else begin
      count_r <= sat ? CW'(els_p) : sum[CW-1:0];
      if (sat)
        overflow_r <= 1'b1;
    end
  end

  assign count_o    = count_r;
  assign overflow_o = overflow_r;

  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(dec_i && (count_r == '0)));

  a_in_range: assert property (@(posedge clk_i) disable iff (reset_i)
    (count_r <= CW'(els_p)));

endmodule

// File: rtl/bsg_fifo_credit_sender.sv
// Producer end of a credit-flow link into a remote small FIFO.
//   clk_i, reset_i : clock and synchronous active-high reset
//   v_i, data_i    : upstream word; taken when v_i & ready_o
//   ready_o        : at least one credit held
//   v_o, data_o    : word launched to the remote FIFO one cycle after acceptance;
//                    data_o holds its last value while v_o is low
//   credit_i       : remote dequeue pulse, worth credit_step_p credits
//   credits_o      : current credit count
//   overflow_o     : sticky, remote returned more credits than els_p
module bsg_fifo_credit_sender
  import bsg_noc_credit_pkg::*;
#(
  parameter int unsigned width_p       = 8,
  parameter int unsigned els_p         = 4,
  parameter int unsigned credit_step_p = 1
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           v_i,
  input  logic [width_p-1:0]             data_i,
  output logic                           ready_o,
  output logic                           v_o,
  output logic [width_p-1:0]             data_o,
  input  logic                           credit_i,
  output logic [credit_width(els_p)-1:0] credits_o,
  output logic                           overflow_o
);

  if (credit_cfg_check(els_p, credit_step_p) != CFG_OK) begin : g_cfg_bad
    $error("bsg_fifo_credit_sender: els_p must be >= 1 and a multiple of credit_step_p");
  end

  logic send;
  logic v_r;
  logic [width_p-1:0] data_r;

  // ready_o is a function of the registered count alone, so upstream never
  // sees a combinational path from its own v_i.
  always_comb begin
    ready_o = (credits_o != '0);
    send    = v_i && ready_o;
  end

  bsg_fifo_credit_counter #(
    .els_p  (els_p),
    .step_p (credit_step_p)
  ) counter (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .dec_i      (send),
    .inc_i      (credit_i),
    .count_o    (credits_o),
    .overflow_o (overflow_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_r    <= 1'b0;
      data_r <= '0;
    end else begin
      v_r <= send;
      if (send)
        data_r <= data_i;
    end
  end

  assign v_o    = v_r;
  assign data_o = data_r;

endmodule

// File: tb/tb_bsg_fifo_credit_sender.sv
module tb_bsg_fifo_credit_sender;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // els_p=4, step=1 instance
  logic       reset4, v_i4, credit_i4;
  logic [7:0] data_i4, data_o4;
  logic       ready4, v_o4, ovf4;
  logic [2:0] credits4;

  // els_p=8, step=2 instance
  logic       reset8, v_i8, credit_i8;
  logic [7:0] data_i8, data_o8;
  logic       ready8, v_o8, ovf8;
  logic [3:0] credits8;

  bsg_fifo_credit_sender #(.width_p(8), .els_p(4), .credit_step_p(1)) dut4 (
    .clk_i(clk), .reset_i(reset4), .v_i(v_i4), .data_i(data_i4),
    .ready_o(ready4), .v_o(v_o4), .data_o(data_o4), .credit_i(credit_i4),
    .credits_o(credits4), .overflow_o(ovf4)
  );

  bsg_fifo_credit_sender #(.width_p(8), .els_p(8), .credit_step_p(2)) dut8 (
    .clk_i(clk), .reset_i(reset8), .v_i(v_i8), .data_i(data_i8),
    .ready_o(ready8), .v_o(v_o8), .data_o(data_o8), .credit_i(credit_i8),
    .credits_o(credits8), .overflow_o(ovf8)
  );

  // {ready, v_o, data_o, credits, overflow}
  logic [13:0] obs4, exp4;
  logic [14:0] obs8, exp8;
  assign obs4 = {ready4, v_o4, data_o4, credits4, ovf4};
  assign obs8 = {ready8, v_o8, data_o8, credits8, ovf8};

  int n_cmp = 0;
  int n_err = 0;

  // Remote FIFO model for dut4: occupancy and the words it has received.
  int        occ4 = 0;
  logic [7:0] remote_q[$];

  task automatic tick();
    logic lv, lc, lr;
    logic [7:0] ld;
    lv = v_o4; lc = credit_i4; lr = reset4; ld = data_o4;
    @(posedge clk);
    if (lr) begin
      occ4 = 0;
      remote_q.delete();
    end else begin
      if (lv) begin
        occ4 = occ4 + 1;
        remote_q.push_back(ld);
      end
      if (lc && occ4 > 0)
        occ4 = occ4 - 1;
    end
    #1;
  endtask

  task automatic check_invariant(string name);
    if (ovf4 == 1'b0) begin
      n_cmp++;
      if (int'(credits4) + occ4 + int'(v_o4) != 4) begin
        n_err++;
        $display("FAIL %s invariant credits=%0d occ=%0d v_o=%0d sum!=4",
                 name, credits4, occ4, v_o4);
      end
    end
  endtask

  task automatic test_reset();
    reset4 = 1'b1; v_i4 = 1'b0; credit_i4 = 1'b0; data_i4 = 8'h00;
    reset8 = 1'b1; v_i8 = 1'b0; credit_i8 = 1'b0; data_i8 = 8'h00;
    tick();
    reset4 = 1'b0; reset8 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    exp4 = {1'b1, 1'b0, 8'h00, 3'd4, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL reset4 got=%h exp=%h", obs4, exp4);
    end
    exp8 = {1'b1, 1'b0, 8'h00, 4'd8, 1'b0};
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL reset8 got=%h exp=%h", obs8, exp8);
    end
  endtask

  task automatic test_fill();
    logic [13:0] tbl[6];
    tbl[0] = {1'b1, 1'b1, 8'h10, 3'd3, 1'b0};
    tbl[1] = {1'b1, 1'b1, 8'h11, 3'd2, 1'b0};
    tbl[2] = {1'b1, 1'b1, 8'h12, 3'd1, 1'b0};
    tbl[3] = {1'b0, 1'b1, 8'h13, 3'd0, 1'b0};
    tbl[4] = {1'b0, 1'b0, 8'h13, 3'd0, 1'b0};
    tbl[5] = {1'b0, 1'b0, 8'h13, 3'd0, 1'b0};
    v_i4 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      data_i4 = 8'h10 + 8'(k);
      tick();
      exp4 = tbl[k];
      n_cmp++;
      if (obs4 !== exp4) begin
        n_err++; $display("FAIL fill_c%0d got=%h exp=%h", k, obs4, exp4);
      end
      check_invariant("fill");
    end
    n_cmp++;
    if (occ4 != 4) begin
      n_err++; $display("FAIL fill_full occ=%0d exp=4", occ4);
    end
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if (k >= remote_q.size() || remote_q[k] !== 8'h10 + 8'(k)) begin
        n_err++;
        $display("FAIL fill_word%0d got=%h exp=%h", k,
                 (k < remote_q.size()) ? remote_q[k] : 8'hxx, 8'h10 + 8'(k));
      end
    end
    // ready_o must not follow v_i
    v_i4 = 1'b0; #1;
    n_cmp++;
    if (ready4 !== 1'b0) begin
      n_err++; $display("FAIL ready_vi0 got=%b exp=0", ready4);
    end
    v_i4 = 1'b1; #1;
    n_cmp++;
    if (ready4 !== 1'b0) begin
      n_err++; $display("FAIL ready_vi1 got=%b exp=0", ready4);
    end
  endtask

  task automatic test_credit_at_empty();
    v_i4 = 1'b1; data_i4 = 8'h20; credit_i4 = 1'b1;
    tick();
    exp4 = {1'b1, 1'b0, 8'h13, 3'd1, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL empty_credit got=%h exp=%h", obs4, exp4);
    end
    credit_i4 = 1'b0;
    tick();
    exp4 = {1'b0, 1'b1, 8'h20, 3'd0, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL empty_send got=%h exp=%h", obs4, exp4);
    end
    v_i4 = 1'b0;
    tick();
    exp4 = {1'b0, 1'b0, 8'h20, 3'd0, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL empty_idle got=%h exp=%h", obs4, exp4);
    end
    check_invariant("empty");
  endtask

  task automatic test_send_and_credit();
    credit_i4 = 1'b1;
    tick(); tick();
    exp4 = {1'b1, 1'b0, 8'h20, 3'd2, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL sc_pre got=%h exp=%h", obs4, exp4);
    end
    v_i4 = 1'b1; data_i4 = 8'h30;
    tick();
    exp4 = {1'b1, 1'b1, 8'h30, 3'd2, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL sc_both got=%h exp=%h", obs4, exp4);
    end
    check_invariant("sc_both");
    v_i4 = 1'b0; credit_i4 = 1'b0;
    tick();
    exp4 = {1'b1, 1'b0, 8'h30, 3'd2, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL sc_after got=%h exp=%h", obs4, exp4);
    end
    check_invariant("sc_after");
  endtask

  task automatic test_overflow();
    // reset wins over same-cycle send and credit
    reset4 = 1'b1; v_i4 = 1'b1; credit_i4 = 1'b1; data_i4 = 8'h77;
    tick();
    exp4 = {1'b1, 1'b0, 8'h00, 3'd4, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL ov_reset_prio got=%h exp=%h", obs4, exp4);
    end
    reset4 = 1'b0; v_i4 = 1'b0; credit_i4 = 1'b1;
    tick();
    exp4 = {1'b1, 1'b0, 8'h00, 3'd4, 1'b1};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL ov_set got=%h exp=%h", obs4, exp4);
    end
    credit_i4 = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL ov_sticky got=%h exp=%h", obs4, exp4);
    end
    v_i4 = 1'b1; data_i4 = 8'h55;
    tick();
    exp4 = {1'b1, 1'b1, 8'h55, 3'd3, 1'b1};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL ov_send got=%h exp=%h", obs4, exp4);
    end
    v_i4 = 1'b0; reset4 = 1'b1;
    tick();
    reset4 = 1'b0;
    tick();
    exp4 = {1'b1, 1'b0, 8'h00, 3'd4, 1'b0};
    n_cmp++;
    if (obs4 !== exp4) begin
      n_err++; $display("FAIL ov_cleared got=%h exp=%h", obs4, exp4);
    end
  endtask

  task automatic test_step2();
    v_i8 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      data_i8 = 8'h40 + 8'(k);
      tick();
      exp8 = {(k != 7), 1'b1, 8'h40 + 8'(k), 4'(7 - k), 1'b0};
      n_cmp++;
      if (obs8 !== exp8) begin
        n_err++; $display("FAIL s2_send%0d got=%h exp=%h", k, obs8, exp8);
      end
    end
    v_i8 = 1'b0; credit_i8 = 1'b1;
    tick();
    exp8 = {1'b1, 1'b0, 8'h47, 4'd2, 1'b0};
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL s2_cred1 got=%h exp=%h", obs8, exp8);
    end
    tick();
    exp8 = {1'b1, 1'b0, 8'h47, 4'd4, 1'b0};
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL s2_cred2 got=%h exp=%h", obs8, exp8);
    end
    credit_i8 = 1'b0; v_i8 = 1'b1; data_i8 = 8'h50;
    tick();
    exp8 = {1'b1, 1'b1, 8'h50, 4'd3, 1'b0};
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL s2_inflight got=%h exp=%h", obs8, exp8);
    end
    reset8 = 1'b1; data_i8 = 8'h51;
    tick();
    exp8 = {1'b1, 1'b0, 8'h00, 4'd8, 1'b0};
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL s2_reset_drop got=%h exp=%h", obs8, exp8);
    end
    reset8 = 1'b0; v_i8 = 1'b0;
    tick();
    n_cmp++;
    if (obs8 !== exp8) begin
      n_err++; $display("FAIL s2_idle got=%h exp=%h", obs8, exp8);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_credit_at_empty();
    test_send_and_credit();
    test_overflow();
    test_step2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
